// File: rtl/gpu.sv
// Rectangle rasterizer feeding a double-buffered 1-bpp framebuffer.
// Draws solid or ROM-sprite rectangles into the back buffer, swaps on vsync, then clears the new back buffer.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   CLEAR  | write 0 to every pixel of the back buffer, ascending
//   IDLE   | op_ready high; accept an op, or swap on vsync if dirty
//   DRAW   | walk the latched rectangle row-major, one pixel per ce-cycle
//   SWAP   | one-cycle swap pulse, front_buf already toggled
module gpu #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int FB_ADDR_W = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 vsync,
  input  logic [59:0]          op,
  input  logic                 op_valid,
  output logic                 op_ready,
  output logic                 swap,
  output logic                 front_buf,
  output logic                 fb_wr_en,
  output logic                 fb_wr_buf,
  output logic [FB_ADDR_W-1:0] fb_wr_addr,
  output logic                 fb_wr_data,
  output logic [10:0]          rom_addr,
  input  logic                 rom_data
);

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_DRAW  = 2'd2;
  localparam logic [1:0] S_SWAP  = 2'd3;

  localparam int                   NPIX      = SCREEN_W * SCREEN_H;
  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(NPIX - 1);
  localparam logic [11:0]          W12       = 12'(SCREEN_W);
  localparam logic [11:0]          H12       = 12'(SCREEN_H);
  localparam logic [FB_ADDR_W-1:0] W_ADDR    = FB_ADDR_W'(SCREEN_W);

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [10:0] width;
    logic [10:0] height;
    logic        color;
    logic        mem_en;
    logic [10:0] mem_addr;
    logic [2:0]  scale;
  } gpu_op_t;

  logic [1:0]           state, next_state;
  logic [FB_ADDR_W-1:0] clr_addr;
  logic                 dirty;
  gpu_op_t              cur;
  logic [10:0]          dx, dy;
  logic                 wr_mem, wr_color;

  logic                 accept, go_swap;
  logic                 clr_last, zero_size, last_col, last_row, draw_done;
  logic [11:0]          px, py;
  logic                 visible;
  logic [FB_ADDR_W-1:0] pix_addr;
  logic [10:0]          dxs, dys, ws, rom_calc;

  assign accept  = (state == S_IDLE) && op_valid && op_ready;
  assign go_swap = (state == S_IDLE) && !accept && vsync && dirty;

  assign clr_last  = (clr_addr == LAST_ADDR);
  assign zero_size = (cur.width == 11'd0) || (cur.height == 11'd0);
  assign last_col  = (dx == cur.width - 11'd1);
  assign last_row  = (dy == cur.height - 11'd1);
  assign draw_done = zero_size || (last_col && last_row);

  // 12-bit sums so coordinates past the screen edge clip instead of wrapping.
  assign px      = {1'b0, cur.x} + {1'b0, dx};
  assign py      = {1'b0, cur.y} + {1'b0, dy};
  assign visible = (px < W12) && (py < H12);
  // Only used for visible pixels, where the result fits the address width.
  assign pix_addr = FB_ADDR_W'(py) * W_ADDR + FB_ADDR_W'(px);

  assign dxs      = dx >> cur.scale;
  assign dys      = dy >> cur.scale;
  assign ws       = cur.width >> cur.scale;
  assign rom_calc = cur.mem_addr + dys * ws + dxs;

  // Combinational from registered counters, so the synchronous ROM answers in
  // the same cycle the pixel write is presented.
  assign rom_addr   = (state == S_DRAW) ? rom_calc : 11'd0;
  assign fb_wr_buf  = ~front_buf;
  assign fb_wr_data = wr_mem ? rom_data : wr_color;

  always_comb begin
    next_state = state;
    case (state)
      S_CLEAR: if (clr_last) next_state = S_IDLE;
      S_IDLE: begin
        if (accept)       next_state = S_DRAW;
        else if (go_swap) next_state = S_SWAP;
      end
      S_DRAW:  if (draw_done) next_state = S_IDLE;
      S_SWAP:  next_state = S_CLEAR;
      default: next_state = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_CLEAR;
      clr_addr   <= '0;
      dirty      <= 1'b0;
      front_buf  <= 1'b1;
      op_ready   <= 1'b0;
      swap       <= 1'b0;
      fb_wr_en   <= 1'b0;
      fb_wr_addr <= '0;
      wr_mem     <= 1'b0;
      wr_color   <= 1'b0;
      cur        <= '0;
      dx         <= '0;
      dy         <= '0;
    end else if (ce) begin
      state    <= next_state;
      op_ready <= (state == S_IDLE) && (next_state == S_IDLE);
      swap     <= go_swap;
      if (go_swap) front_buf <= ~front_buf;
      fb_wr_en <= 1'b0;
      wr_mem   <= 1'b0;
      wr_color <= 1'b0;

      case (state)
        S_CLEAR: begin
          fb_wr_en   <= 1'b1;
          fb_wr_addr <= clr_addr;
          clr_addr   <= clr_last ? '0 : clr_addr + FB_ADDR_W'(1);
          dirty      <= 1'b0;
        end
        S_IDLE: begin
          if (accept) begin
            cur   <= gpu_op_t'(op);
            dx    <= '0;
            dy    <= '0;
            dirty <= 1'b1;
          end
        end
        S_DRAW: begin
          if (!zero_size) begin
            fb_wr_en   <= visible;
            fb_wr_addr <= pix_addr;
            wr_mem     <= cur.mem_en;
            wr_color   <= cur.color;
            if (last_col) begin
              dx <= '0;
              dy <= dy + 11'd1;
            end else begin
              dx <= dx + 11'd1;
            end
          end
        end
        S_SWAP: clr_addr <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu.sv
// Self-checking bench for gpu on an 8x4 screen: vector table, random ops vs a pixel-list model,
// plus hand sequences for swap, ce stretching and reset mid-draw.
module tb_gpu;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst, ce, vsync, op_valid;
  logic [59:0]   op;
  logic          op_ready, swap, front_buf, fb_wr_en, fb_wr_buf, fb_wr_data;
  logic [AW-1:0] fb_wr_addr;
  logic [10:0]   rom_addr;
  logic          rom_data = 1'b0;

  always #5 clk = ~clk;

  gpu #(.SCREEN_W(W), .SCREEN_H(H), .FB_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .ce(ce), .vsync(vsync),
    .op(op), .op_valid(op_valid), .op_ready(op_ready),
    .swap(swap), .front_buf(front_buf),
    .fb_wr_en(fb_wr_en), .fb_wr_buf(fb_wr_buf), .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  logic rom_mem [2048];
  always @(posedge clk) if (ce) rom_data <= rom_mem[rom_addr];

  typedef struct packed {
    logic          b;
    logic [AW-1:0] a;
    logic          d;
  } wr_t;

  typedef struct {
    int x, y, w, h;
    bit color, mem;
    int maddr, scale;
  } op_s;

  typedef struct {
    op_s o;
    int  exp_busy;
    int  exp_nwr;
    int  exp_first;
  } vec_t;

  wr_t got[$];
  wr_t exp_wr[$];
  int  exp_rom[$];
  int  rom_got[$];
  int  swap_cnt = 0;
  int  checks = 0;
  int  errors = 0;
  bit  exp_front = 1'b1;

  // Records each freshly registered write (one per ce edge with fb_wr_en set).
  always begin
    @(posedge clk);
    #1;
    if (!rst && ce && fb_wr_en) got.push_back('{fb_wr_buf, fb_wr_addr, fb_wr_data});
    if (!rst && ce && swap) swap_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [59:0] pack(input op_s o);
    return {11'(o.x), 11'(o.y), 11'(o.w), 11'(o.h), o.color, o.mem, 11'(o.maddr), 3'(o.scale)};
  endfunction

  // Reference: the pixel list a rectangle produces, straight from the drawing rules.
  task automatic model(input op_s o, input bit bufsel);
    exp_wr.delete();
    exp_rom.delete();
    for (int dy = 0; dy < o.h; dy++)
      for (int dx = 0; dx < o.w; dx++) begin
        int px, py, ra;
        bit d;
        px = o.x + dx;
        py = o.y + dy;
        ra = (o.maddr + (dy >> o.scale) * (o.w >> o.scale) + (dx >> o.scale)) % 2048;
        exp_rom.push_back(ra);
        d = o.mem ? rom_mem[ra] : o.color;
        if (px < W && py < H) exp_wr.push_back('{bufsel, AW'(py * W + px), d});
      end
  endtask

  function automatic int model_busy(input op_s o);
    return (o.w == 0 || o.h == 0) ? 2 : o.w * o.h + 1;
  endfunction

  // mode: 0 ce high, 1 ce alternating, 2 ce random. Returns ce-cycle and clock busy counts.
  task automatic do_op(input op_s o, input int mode, input bit vs_draw,
                       output int busy, output int clocks);
    int  n;
    bit  ce_prev;
    n = 0;
    ce = 1'b1;
    while (!op_ready && n < 200) begin cyc(); n++; end
    check("op_ready before op", op_ready, 1'b1);
    model(o, ~exp_front);
    got.delete();
    rom_got.delete();
    op = pack(o);
    op_valid = 1'b1;
    cyc();
    op_valid = 1'b0;
    op = '0;
    busy = 0;
    clocks = 0;
    ce_prev = 1'b1;
    n = 0;
    while (n < 2000) begin
      if (ce_prev) begin
        if (op_ready) break;
        busy++;
        if (rom_got.size() < o.w * o.h) rom_got.push_back(int'(rom_addr));
      end
      clocks++;
      vsync = vs_draw && (n == 0);
      case (mode)
        1:       ce = ~ce_prev;
        2:       ce = 1'($urandom_range(0, 1));
        default: ce = 1'b1;
      endcase
      ce_prev = ce;
      cyc();
      n++;
    end
    vsync = 1'b0;
    ce = 1'b1;
    check("op completion timeout", (n < 2000), 1'b1);
    check("write count", got.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < got.size(); i++)
      check($sformatf("write %0d {buf,addr,data}", i), got[i], exp_wr[i]);
    if (o.mem)
      for (int i = 0; i < exp_rom.size() && i < rom_got.size(); i++)
        check($sformatf("rom_addr pixel %0d", i), rom_got[i], exp_rom[i]);
  endtask

  task automatic check_clear(input bit bufsel);
    check("clear write count", got.size(), 32);
    for (int i = 0; i < 32 && i < got.size(); i++)
      check($sformatf("clear %0d", i), got[i], {bufsel, AW'(i), 1'b0});
  endtask

  initial begin
    vec_t vecs[6];
    int   busy, clocks;
    op_s  o;

    for (int i = 0; i < 2048; i++) rom_mem[i] = 1'($urandom_range(0, 1));

    //            x  y  w  h  col mem maddr sc    busy nwr first
    vecs[0] = '{'{2, 1, 3, 2, 1, 0, 0,    0},   7,   6,  10};
    vecs[1] = '{'{6, 3, 4, 2, 1, 0, 0,    0},   9,   2,  30};
    vecs[2] = '{'{0, 0, 4, 2, 0, 1, 100,  1},   9,   8,  0};
    vecs[3] = '{'{0, 0, 8, 4, 1, 0, 0,    0},   33,  32, 0};
    vecs[4] = '{'{3, 2, 0, 3, 1, 0, 0,    0},   2,   0,  -1};
    vecs[5] = '{'{5, 0, 6, 3, 0, 1, 2040, 2},   19,  9,  5};

    rst = 1'b1; ce = 1'b1; vsync = 1'b0; op_valid = 1'b0; op = '0;
    repeat (3) cyc();
    check("reset op_ready", op_ready, 1'b0);
    check("reset swap", swap, 1'b0);
    check("reset fb_wr_en", fb_wr_en, 1'b0);
    check("reset front_buf", front_buf, 1'b1);
    check("reset fb_wr_addr", fb_wr_addr, 0);
    check("reset fb_wr_data", fb_wr_data, 1'b0);
    check("reset rom_addr", rom_addr, 0);

    got.delete();
    rst = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      cyc();
      if (i == 32) check("op_ready low cycle 32", op_ready, 1'b0);
      if (i == 33) check("op_ready high cycle 33", op_ready, 1'b1);
    end
    check_clear(1'b0);

    vsync = 1'b1; cyc(); vsync = 1'b0;
    repeat (3) cyc();
    check("no swap when clean", swap_cnt, 0);
    check("front_buf after clean vsync", front_buf, 1'b1);

    foreach (vecs[i]) begin
      do_op(vecs[i].o, 0, 1'b0, busy, clocks);
      check($sformatf("vec %0d busy", i), busy, vecs[i].exp_busy);
      check($sformatf("vec %0d nwr", i), got.size(), vecs[i].exp_nwr);
      if (vecs[i].exp_first >= 0 && got.size() > 0)
        check($sformatf("vec %0d first addr", i), got[0].a, vecs[i].exp_first);
    end

    for (int k = 0; k < 25; k++) begin
      o.x = $urandom_range(0, 9);     o.y = $urandom_range(0, 5);
      o.w = $urandom_range(0, 5);     o.h = $urandom_range(0, 4);
      o.color = 1'($urandom_range(0, 1)); o.mem = 1'($urandom_range(0, 1));
      o.maddr = $urandom_range(0, 2047);  o.scale = $urandom_range(0, 3);
      do_op(o, (k % 2) * 2, 1'b0, busy, clocks);
      check($sformatf("rand %0d busy", k), busy, model_busy(o));
    end

    // vsync in DRAW is dropped; a later vsync in IDLE swaps.
    swap_cnt = 0;
    o = '{1, 1, 2, 2, 1, 0, 0, 0};
    do_op(o, 0, 1'b1, busy, clocks);
    repeat (3) cyc();
    check("no swap from vsync in draw", swap_cnt, 0);
    got.delete();
    vsync = 1'b1; cyc(); vsync = 1'b0;
    check("swap pulse", swap, 1'b1);
    check("front_buf toggled", front_buf, 1'b0);
    cyc();
    check("swap one cycle", swap, 1'b0);
    exp_front = 1'b0;
    repeat (34) cyc();
    check("swap count", swap_cnt, 1);
    check_clear(1'b1);
    vsync = 1'b1; cyc(); vsync = 1'b0;
    repeat (3) cyc();
    check("no swap after clear", swap_cnt, 1);

    do_op(vecs[0].o, 1, 1'b0, busy, clocks);
    check("ce half busy", busy, 7);
    check("ce half clocks", clocks, 14);

    // Reset in the middle of a full-screen draw.
    o = '{0, 0, 8, 4, 1, 0, 0, 0};
    op = pack(o); op_valid = 1'b1; cyc(); op_valid = 1'b0;
    repeat (5) cyc();
    got.delete();
    rst = 1'b1;
    cyc();
    check("rst mid-draw fb_wr_en", fb_wr_en, 1'b0);
    check("rst mid-draw front_buf", front_buf, 1'b1);
    cyc();
    check("rst mid-draw op_ready", op_ready, 1'b0);
    check("rst mid-draw no writes", got.size(), 0);
    exp_front = 1'b1;
    rst = 1'b0;
    repeat (33) cyc();
    check("op_ready after re-clear", op_ready, 1'b1);
    check_clear(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
